// File: rtl/dp_mem_responder.sv
// dp_mem_responder: memory-side responder with a direct-mapped icache, uncached data path and halt flush
// Ports: CLK/nRST (async, active-high) | halt -> flushed (sticky)
//        imemREN/imemaddr -> imemload/ihit | dmemREN/dmemWEN/dmemaddr/dmemstore -> dmemload/dhit
//        ramREN/ramWEN/ramaddr/ramstore <-> ramload/ramready (single shared word-wide RAM port)
module dp_mem_responder #(
    parameter int ISETS  = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              halt,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] imemload,
    output logic              ihit,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload,
    output logic              dhit,
    output logic              flushed,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);
    localparam int IW = $clog2(ISETS);
    localparam int TW = WORD_W - 2 - IW;
    localparam logic [WORD_W-1:0] WMASK = ~WORD_W'(3);

    typedef enum logic [2:0] {IDLE, DACC, IFILL, FLUSH, HALTED} state_t;
    state_t st, nxt;

    logic [TW-1:0]     tags [ISETS];
    logic [WORD_W-1:0] data [ISETS];
    logic [ISETS-1:0]  vld;
    logic [WORD_W-1:0] faddr;
    logic [IW-1:0]     iidx, didx, fidx;
    logic [TW-1:0]     itag, dtag, ftag;
    logic              fill_done, inval;

    assign iidx = imemaddr[IW+1:2];
    assign itag = imemaddr[WORD_W-1:IW+2];
    assign didx = dmemaddr[IW+1:2];
    assign dtag = dmemaddr[WORD_W-1:IW+2];
    assign fidx = faddr[IW+1:2];
    assign ftag = faddr[WORD_W-1:IW+2];

    assign ihit      = imemREN & vld[iidx] & (tags[iidx] == itag) & (st != HALTED);
    assign imemload  = ihit ? data[iidx] : '0;
    assign fill_done = (st == IFILL) & ramready;
    // a write to a cached word drops that entry so the next fetch refetches it
    assign inval     = (st == DACC) & ramready & dmemWEN & vld[didx] & (tags[didx] == dtag);

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            st      <= IDLE;
            faddr   <= '0;
            flushed <= 1'b0;
        end else begin
            st      <= nxt;
            faddr   <= (st == IDLE && nxt == IFILL) ? imemaddr : faddr;
            flushed <= flushed | (st == FLUSH);
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            vld <= '0;
        end else if (st == FLUSH) begin
            vld <= '0;
        end else begin
            if (fill_done) vld[fidx] <= 1'b1;
            if (inval) vld[didx] <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fidx] <= ftag;
            data[fidx] <= ramload;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:        nxt = (dmemREN | dmemWEN) ? DACC : halt ? FLUSH : (imemREN & ~ihit) ? IFILL : IDLE;
            DACC, IFILL: nxt = ramready ? IDLE : st;
            FLUSH:       nxt = HALTED;
            default:     nxt = HALTED;
        endcase
    end

    always_comb begin
        ramREN   = ((st == DACC) & ~dmemWEN) | (st == IFILL);
        ramWEN   = (st == DACC) & dmemWEN;
        ramaddr  = (st == DACC) ? (dmemaddr & WMASK) : (st == IFILL) ? (faddr & WMASK) : '0;
        ramstore = (st == DACC) ? dmemstore : '0;
        dhit     = (st == DACC) & ramready;
        dmemload = (dhit & ~dmemWEN) ? ramload : '0;
    end
endmodule

// File: tb/tb_dp_mem_responder.sv
// tb_dp_mem_responder: directed self-checking bench for dp_mem_responder
module tb_dp_mem_responder;
    logic        CLK = 1'b0, nRST = 1'b1, halt = 1'b0;
    logic        imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, ramready = 1'b0;
    logic [31:0] imemaddr = '0, dmemaddr = '0, dmemstore = '0, ramload = '0;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;
    logic        ihit, dhit, flushed, ramREN, ramWEN;
    int          n_assert = 0, n_fail = 0;

    dp_mem_responder dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload(dmemload), .dhit(dhit), .flushed(flushed),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_flushed", 32'(flushed), 0);
        chk("rst_ramaddr", ramaddr, 0);
        tick(); tick();
        nRST = 1'b0;
        imemREN = 1'b1; imemaddr = 32'h40; #1;
        chk("t1_idle_miss", 32'(ihit), 0);
        chk("t1_idle_ren", 32'(ramREN), 0);
        tick(); #1;
        chk("t1_ren_c1", 32'(ramREN), 1);
        chk("t1_addr", ramaddr, 32'h40);
        tick(); #1;
        chk("t1_ren_c2", 32'(ramREN), 1);
        tick(); ramready = 1'b1; ramload = 32'h2001_0005; #1;
        chk("t1_ren_c3", 32'(ramREN), 1);
        chk("t1_no_early_ihit", 32'(ihit), 0);
        tick(); ramready = 1'b0; ramload = '0; #1;
        chk("t1_ihit", 32'(ihit), 1);
        chk("t1_load", imemload, 32'h2001_0005);
        chk("t1_ren_off", 32'(ramREN), 0);
        tick(); #1;
        chk("t1_rehit", 32'(ihit), 1);
        chk("t1_rehit_ren", 32'(ramREN), 0);
        imemaddr = 32'h80; #1;
        chk("t2_conflict_miss", 32'(ihit), 0);
        tick(); ramready = 1'b1; ramload = 32'h1111_1111; #1;
        chk("t2_fill_addr", ramaddr, 32'h80);
        tick(); ramready = 1'b0; #1;
        chk("t2_hit80", 32'(ihit), 1);
        chk("t2_load80", imemload, 32'h1111_1111);
        imemaddr = 32'h40; #1;
        chk("t2_tag_replaced", 32'(ihit), 0);
        tick(); ramready = 1'b1; ramload = 32'h2001_0005; #1;
        tick(); ramready = 1'b0; #1;
        chk("t2_hit40", 32'(ihit), 1);
        imemaddr = 32'h44; dmemREN = 1'b1; dmemaddr = 32'h100; #1;
        chk("t3_imiss", 32'(ihit), 0);
        tick(); ramready = 1'b1; ramload = 32'hCAFE_0001; #1;
        chk("t3_dacc_addr", ramaddr, 32'h100);
        chk("t3_dacc_ren", 32'(ramREN), 1);
        chk("t3_dhit", 32'(dhit), 1);
        chk("t3_dload", dmemload, 32'hCAFE_0001);
        chk("t3_no_ihit", 32'(ihit), 0);
        tick(); ramready = 1'b0; dmemREN = 1'b0; #1;
        chk("t3_dhit_once", 32'(dhit), 0);
        chk("t3_idle_ren", 32'(ramREN), 0);
        chk("t3_idle_ihit", 32'(ihit), 0);
        tick(); ramready = 1'b1; ramload = 32'h0A0A_0A0A; #1;
        chk("t3_fill_addr", ramaddr, 32'h44);
        chk("t3_fill_ihit", 32'(ihit), 0);
        tick(); ramready = 1'b0; #1;
        chk("t3_hit44", 32'(ihit), 1);
        chk("t3_load44", imemload, 32'h0A0A_0A0A);
        imemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hDEAD_BEEF;
        tick(); #1;
        chk("t4_wen", 32'(ramWEN), 1);
        chk("t4_ren", 32'(ramREN), 0);
        chk("t4_store", ramstore, 32'hDEAD_BEEF);
        chk("t4_wait_dhit", 32'(dhit), 0);
        ramready = 1'b1; ramload = 32'h5555_5555; #1;
        chk("t4_dhit", 32'(dhit), 1);
        chk("t4_dload_zero", dmemload, 0);
        tick(); ramready = 1'b0; dmemWEN = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; #1;
        chk("t4_inval_miss", 32'(ihit), 0);
        tick(); ramready = 1'b1; ramload = 32'hDEAD_BEEF; #1;
        tick(); ramready = 1'b0; #1;
        chk("t4_refill", imemload, 32'hDEAD_BEEF);
        imemaddr = 32'h48; #1;
        chk("t5_miss", 32'(ihit), 0);
        tick(); halt = 1'b1; #1;
        chk("t5_fill_holds", 32'(ramREN), 1);
        tick(); ramready = 1'b1; ramload = 32'h1234_5678; #1;
        chk("t5_fill_done_ren", 32'(ramREN), 1);
        tick(); ramready = 1'b0; #1;
        chk("t5_idle_hit", 32'(ihit), 1);
        chk("t5_not_flushed", 32'(flushed), 0);
        tick(); #1;
        chk("t5_flush_flushed", 32'(flushed), 0);
        tick(); #1;
        chk("t5_flushed", 32'(flushed), 1);
        chk("t5_halted_ihit", 32'(ihit), 0);
        chk("t5_halted_ren", 32'(ramREN), 0);
        halt = 1'b0;
        tick(); tick(); #1;
        chk("t5_sticky", 32'(flushed), 1);
        nRST = 1'b1; #1;
        chk("t5_rst_flushed", 32'(flushed), 0);
        tick(); nRST = 1'b0; imemaddr = 32'h40; #1;
        chk("t5_cleared_40", 32'(ihit), 0);
        imemaddr = 32'h48; #1;
        chk("t5_cleared_48", 32'(ihit), 0);
        imemREN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h100;
        tick(); #1;
        chk("t6_dacc_ren", 32'(ramREN), 1);
        ramready = 1'b1; nRST = 1'b1; #1;
        chk("t6_rst_ren", 32'(ramREN), 0);
        chk("t6_rst_wen", 32'(ramWEN), 0);
        chk("t6_rst_dhit", 32'(dhit), 0);
        chk("t6_rst_flushed", 32'(flushed), 0);
        tick(); nRST = 1'b0; dmemREN = 1'b0; ramready = 1'b0; #1;
        chk("t6_idle_ren", 32'(ramREN), 0);
        chk("t6_idle_dhit", 32'(dhit), 0);
        imemREN = 1'b1; imemaddr = 32'h4C;
        tick(); #1;
        chk("t6_idle_to_fill", 32'(ramREN), 1);
        chk("t6_fill_addr", ramaddr, 32'h4C);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
